bridge_commutator: RTL and testbench
====================================

# bridge_commutator

Sequencer between the command decoder and the H-bridge gate drivers. Accepts requested bridge modes (OFF, PLUS, MINUS, BALLAST_P, BALLAST_N) over a valid/ready handshake and drives the TOP/BOT gate vector plus mode indicator lines. Guarantees a dead-time (all switches off) at every commutation. Forces all switches off on any driver fault until the fault is explicitly cleared.

## Interface
- FREQ, 50_000_000: clk frequency, Hz.
- DEAD_NS, 2000: dead-time, ns; DEAD_CYC = ceil(FREQ*DEAD_NS/1e9), minimum 1.
- MIN_ON_NS, 10000: minimum on-time, ns; MIN_ON_CYC derived the same way. Used only with BRIDGE_MIN_ON_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  mode request valid.
- req_mode  in  3  bridge_mode_t; codes 5..7 are illegal and decode as OFF.
- req_ready  out  1  request accepted when req_valid & req_ready.
- err_n  in  4  driver fault inputs, active-low, asynchronous.
- err_clr  in  1  fault clear strobe.
- top, bot  out  4 each  gate drives.
- o_plus, o_minus, o_pause_p, o_pause_n  out  1 each  mode indicators.
- busy  out  1  high in S_DEAD.
- fault  out  1  high in S_FAULT.
- fault_src  out  4  latched OR of the asserted fault bits (1 = that driver faulted).

## Operation
- Mode map (top/bot/indicator):
  - OFF: 0000/0000, none.
  - PLUS: 0001/0010, o_plus.
  - MINUS: 0010/0001, o_minus.
  - BALLAST_P: 0100/1000, o_pause_p.
  - BALLAST_N: 1000/0100, o_pause_n.
- All outputs are registered. Reset value of every output is 0, except req_ready = 1.
- State S_OFF: ready = 1.
  - Accepted non-OFF mode: outputs take that mode next cycle; go to S_ON.
  - Accepted OFF: no-op.
- State S_ON: ready = 1.
  - Same mode: no-op.
  - Different mode, including OFF: outputs go all-zero next cycle; latch the target; go to S_DEAD.
- State S_DEAD: ready = 0, outputs 0, counter counts DEAD_CYC cycles.
  - On expiry with target non-OFF: apply the target, go to S_ON.
  - On expiry with target OFF: go to S_OFF.
- State S_FAULT: outputs 0; ready = 1; accepted requests are discarded.
  - err_clr is honoured only when all synchronized err_n bits are high. It clears fault_src and enters S_DEAD with target OFF.
- Fault entry:
  - err_n passes through a 2-flop synchronizer.
  - Any low bit, from any state, moves to S_FAULT and ORs ~err_n into fault_src.
  - Fault takes priority over a same-cycle request and over dead-time expiry.
- Top and bottom switches of the same leg pair are never driven on in the same cycle. No change between two non-OFF modes occurs without ≥ DEAD_CYC all-zero cycles.

## Timing
- err_n edge to outputs zero: ≤ 3 clk cycles (2 sync stages + 1 register).
- Accept in S_OFF to new mode on the outputs: 1 cycle.
- Accept of a different mode in S_ON at cycle N:
  - outputs zero at N+1;
  - new mode at N+1+DEAD_CYC;
  - busy high for exactly DEAD_CYC cycles.
- Reset mid-S_DEAD or mid-S_ON: outputs zero immediately (asynchronous); state S_OFF; counters cleared.
- Dead counter width: $clog2(DEAD_CYC+1). It loads at entry to S_DEAD and never wraps.

## Configuration
- BRIDGE_MIN_ON_EN defined:
  - A counter loads MIN_ON_CYC on each entry to S_ON.
  - req_ready stays 0 in S_ON until the counter expires.
  - Fault still preempts immediately.
- BRIDGE_MIN_ON_EN undefined: no min-on counter; MIN_ON_NS is ignored; S_ON is always ready.

## Structure
- Package bridge_pkg holds:
  - bridge_mode_t enum;
  - state enum (S_OFF, S_ON, S_DEAD, S_FAULT);
  - mode_to_top / mode_to_bot / mode_to_ind functions;
  - ns_to_cyc function.
- One sub-module: sync_2ff, parameterized width, instantiated for err_n (width 4).

## Test plan
Test values: FREQ=50e6, DEAD_CYC=100, MIN_ON_CYC=500.
- Reset release -> all outputs 0, req_ready=1, fault=0, fault_src=0000.
- Accept PLUS at cycle N from S_OFF -> at N+1 top=0001, bot=0010, o_plus=1.
- PLUS then accept MINUS at N -> N+1..N+100 outputs 0, busy=1, ready=0; at N+101 top=0010, bot=0001, o_minus=1.
- In PLUS, drive err_n=1101 -> outputs 0 within 3 cycles, fault=1, fault_src=0010.
  - err_clr while err_n=1101 -> ignored.
  - err_n=1111 then err_clr -> 100 dead cycles, then S_OFF, fault=0, fault_src=0000.
- Accept req_mode=5 while in BALLAST_P -> treated as OFF: outputs 0 for 100 cycles, then S_OFF.
- BRIDGE_MIN_ON_EN defined: request MINUS 10 cycles after PLUS is applied -> ready=0 until 500 cycles in S_ON, then accepted.
  - Undefined: the same request is accepted immediately.

Source files
------------

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the H-bridge commutator: bridge modes, FSM states,
// per-mode gate/indicator maps and the ns-to-cycle conversion used for timer sizing.
package bridge_pkg;

  localparam int unsigned LEG_W = 4;

  typedef enum logic [2:0] {
    MODE_OFF       = 3'd0,
    MODE_PLUS      = 3'd1,
    MODE_MINUS     = 3'd2,
    MODE_BALLAST_P = 3'd3,
    MODE_BALLAST_N = 3'd4
  } bridge_mode_t;

  typedef enum logic [1:0] {
    S_OFF   = 2'd0,
    S_ON    = 2'd1,
    S_DEAD  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Codes 5..7 have no bridge meaning and are treated as a request to switch off.
  function automatic bridge_mode_t decode_mode(input logic [2:0] code);
    case (code)
      3'd1:    return MODE_PLUS;
      3'd2:    return MODE_MINUS;
      3'd3:    return MODE_BALLAST_P;
      3'd4:    return MODE_BALLAST_N;
      default: return MODE_OFF;
    endcase
  endfunction

  function automatic logic [LEG_W-1:0] mode_to_top(input bridge_mode_t m);
    case (m)
      MODE_PLUS:      return 4'b0001;
      MODE_MINUS:     return 4'b0010;
      MODE_BALLAST_P: return 4'b0100;
      MODE_BALLAST_N: return 4'b1000;
      default:        return 4'b0000;
    endcase
  endfunction

  function automatic logic [LEG_W-1:0] mode_to_bot(input bridge_mode_t m);
    case (m)
      MODE_PLUS:      return 4'b0010;
      MODE_MINUS:     return 4'b0001;
      MODE_BALLAST_P: return 4'b1000;
      MODE_BALLAST_N: return 4'b0100;
      default:        return 4'b0000;
    endcase
  endfunction

  // Indicator vector ordering: {pause_n, pause_p, minus, plus}.
  function automatic logic [3:0] mode_to_ind(input bridge_mode_t m);
    case (m)
      MODE_PLUS:      return 4'b0001;
      MODE_MINUS:     return 4'b0010;
      MODE_BALLAST_P: return 4'b0100;
      MODE_BALLAST_N: return 4'b1000;
      default:        return 4'b0000;
    endcase
  endfunction

  // Rounds up so the realised interval is never shorter than requested; at least one cycle.
  function automatic int unsigned ns_to_cyc(input longint unsigned freq, input longint unsigned ns);
    longint unsigned cyc;
    cyc = (freq * ns + 64'd999_999_999) / 64'd1_000_000_000;
    return (cyc == 64'd0) ? 32'd1 : 32'(cyc);
  endfunction

endpackage

// File: rtl/bridge_commutator_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; reset value is parameterised
// so active-low fault lines come out of reset in their inactive state.
module sync_2ff #(
  parameter int unsigned       WIDTH   = 1,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/bridge_commutator.sv
// H-bridge mode sequencer with enforced dead-time between commutations and latched
// driver-fault shutdown. Optional minimum on-time gating via BRIDGE_MIN_ON_EN.
module bridge_commutator
  import bridge_pkg::*;
#(
  parameter int unsigned FREQ      = 50_000_000,
  parameter int unsigned DEAD_NS   = 2000,
  parameter int unsigned MIN_ON_NS = 10000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  input  logic [2:0]       req_mode,
  output logic             req_ready,
  input  logic [3:0]       err_n,
  input  logic             err_clr,
  output logic [LEG_W-1:0] top,
  output logic [LEG_W-1:0] bot,
  output logic             o_plus,
  output logic             o_minus,
  output logic             o_pause_p,
  output logic             o_pause_n,
  output logic             busy,
  output logic             fault,
  output logic [3:0]       fault_src
);

  localparam int unsigned DEAD_CYC = ns_to_cyc(64'(FREQ), 64'(DEAD_NS));
  localparam int unsigned DEAD_W   = $clog2(DEAD_CYC + 1);

`ifdef BRIDGE_MIN_ON_EN
  localparam int unsigned MIN_ON_CYC = ns_to_cyc(64'(FREQ), 64'(MIN_ON_NS));
  localparam int unsigned MIN_W      = $clog2(MIN_ON_CYC + 1);
  logic [MIN_W-1:0] min_q, min_d;
`endif

  state_t           state_q, state_d;
  bridge_mode_t     cur_q, cur_d;
  bridge_mode_t     tgt_q, tgt_d;
  bridge_mode_t     req_m;
  logic [DEAD_W-1:0] dead_q, dead_d;
  logic [3:0]       err_sync;
  logic [3:0]       src_d;
  logic [LEG_W-1:0] top_d, bot_d;
  logic [3:0]       ind_d;
  logic             ready_d, busy_d, fault_d;
  logic             accept, fault_any;

  sync_2ff #(.WIDTH(4), .RST_VAL(4'hF)) u_err_sync (
    .clk (clk),
    .rst (rst),
    .d   (err_n),
    .q   (err_sync)
  );

  assign req_m     = decode_mode(req_mode);
  assign accept    = req_valid & req_ready;
  assign fault_any = ~&err_sync;

  // State, timers and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_OFF;
      cur_q     <= MODE_OFF;
      tgt_q     <= MODE_OFF;
      dead_q    <= '0;
      fault_src <= '0;
      top       <= '0;
      bot       <= '0;
      o_plus    <= 1'b0;
      o_minus   <= 1'b0;
      o_pause_p <= 1'b0;
      o_pause_n <= 1'b0;
      busy      <= 1'b0;
      fault     <= 1'b0;
      req_ready <= 1'b1;
`ifdef BRIDGE_MIN_ON_EN
      min_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cur_q     <= cur_d;
      tgt_q     <= tgt_d;
      dead_q    <= dead_d;
      fault_src <= src_d;
      top       <= top_d;
      bot       <= bot_d;
      o_plus    <= ind_d[0];
      o_minus   <= ind_d[1];
      o_pause_p <= ind_d[2];
      o_pause_n <= ind_d[3];
      busy      <= busy_d;
      fault     <= fault_d;
      req_ready <= ready_d;
`ifdef BRIDGE_MIN_ON_EN
      min_q     <= min_d;
`endif
    end
  end

  // Next-state and next-output logic; fault overrides every other transition.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dead_d  = dead_q;
    src_d   = fault_src;
`ifdef BRIDGE_MIN_ON_EN
    min_d   = min_q;
`endif

    if (fault_any) begin
      state_d = S_FAULT;
      cur_d   = MODE_OFF;
      dead_d  = '0;
      src_d   = fault_src | ~err_sync;
`ifdef BRIDGE_MIN_ON_EN
      min_d   = '0;
`endif
    end else begin
      case (state_q)
        S_OFF: begin
          if (accept && req_m != MODE_OFF) begin
            state_d = S_ON;
            cur_d   = req_m;
`ifdef BRIDGE_MIN_ON_EN
            min_d   = MIN_W'(MIN_ON_CYC);
`endif
          end
        end
        S_ON: begin
`ifdef BRIDGE_MIN_ON_EN
          if (min_q != '0) min_d = min_q - MIN_W'(1);
`endif
          if (accept && req_m != cur_q) begin
            state_d = S_DEAD;
            tgt_d   = req_m;
            cur_d   = MODE_OFF;
            dead_d  = DEAD_W'(DEAD_CYC);
          end
        end
        S_DEAD: begin
          if (dead_q <= DEAD_W'(1)) begin
            dead_d = '0;
            if (tgt_q != MODE_OFF) begin
              state_d = S_ON;
              cur_d   = tgt_q;
`ifdef BRIDGE_MIN_ON_EN
              min_d   = MIN_W'(MIN_ON_CYC);
`endif
            end else begin
              state_d = S_OFF;
              cur_d   = MODE_OFF;
            end
          end else begin
            dead_d = dead_q - DEAD_W'(1);
          end
        end
        S_FAULT: begin
          // Lines are known healthy here, so a clear strobe is honoured.
          if (err_clr) begin
            state_d = S_DEAD;
            tgt_d   = MODE_OFF;
            src_d   = '0;
            dead_d  = DEAD_W'(DEAD_CYC);
          end
        end
        default: state_d = S_OFF;
      endcase
    end

    top_d = '0;
    bot_d = '0;
    ind_d = '0;
    if (state_d == S_ON) begin
      top_d = mode_to_top(cur_d);
      bot_d = mode_to_bot(cur_d);
      ind_d = mode_to_ind(cur_d);
    end
    busy_d  = (state_d == S_DEAD);
    fault_d = (state_d == S_FAULT);
    ready_d = (state_d != S_DEAD);
`ifdef BRIDGE_MIN_ON_EN
    if (state_d == S_ON && min_d != '0) ready_d = 1'b0;
`endif
  end

endmodule

// File: tb/tb_bridge_commutator.sv
// Directed bench for bridge_commutator at default parameters (dead-time 100 cycles,
// min on-time 500 cycles when BRIDGE_MIN_ON_EN is defined).
module tb_bridge_commutator;

  localparam logic [2:0] M_OFF = 3'd0;
  localparam logic [2:0] M_PLUS = 3'd1;
  localparam logic [2:0] M_MINUS = 3'd2;
  localparam logic [2:0] M_BP = 3'd3;
  localparam logic [2:0] M_BN = 3'd4;
  localparam logic [2:0] M_ILL = 3'd5;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [2:0] req_mode;
  logic       req_ready;
  logic [3:0] err_n;
  logic       err_clr;
  logic [3:0] top, bot;
  logic       o_plus, o_minus, o_pause_p, o_pause_n;
  logic       busy, fault;
  logic [3:0] fault_src;
  logic [3:0] ind;

  int checks = 0;
  int errors = 0;

  assign ind = {o_pause_n, o_pause_p, o_minus, o_plus};

  bridge_commutator dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_mode  (req_mode),
    .req_ready (req_ready),
    .err_n     (err_n),
    .err_clr   (err_clr),
    .top       (top),
    .bot       (bot),
    .o_plus    (o_plus),
    .o_minus   (o_minus),
    .o_pause_p (o_pause_p),
    .o_pause_n (o_pause_n),
    .busy      (busy),
    .fault     (fault),
    .fault_src (fault_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] m);
    req_mode  = m;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Counts consecutive busy cycles (and ready-low cycles among them) from now.
  task automatic run_dead(output int busy_n, output int ready_low);
    busy_n = 0;
    ready_low = 0;
    for (int i = 0; i < 300 && busy; i++) begin
      busy_n++;
      if (!req_ready) ready_low++;
      tick();
    end
  endtask

  task automatic check_mode(input string tag, input logic [3:0] t, input logic [3:0] b,
                            input logic [3:0] i);
    check({tag, "_top"}, 32'(top), 32'(t));
    check({tag, "_bot"}, 32'(bot), 32'(b));
    check({tag, "_ind"}, 32'(ind), 32'(i));
  endtask

  always @(negedge clk) begin
    if (!rst) check("overlap", 32'(top & bot), 32'd0);
  end

  initial begin
    int bn, rl, n;
    rst = 1'b1;
    req_valid = 1'b0;
    req_mode = M_OFF;
    err_n = 4'hF;
    err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    tick();

    check_mode("reset", 4'h0, 4'h0, 4'h0);
    check("reset_ready", 32'(req_ready), 32'd1);
    check("reset_fault", 32'(fault), 32'd0);
    check("reset_src", 32'(fault_src), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);

    send(M_PLUS);
    check_mode("plus", 4'b0001, 4'b0010, 4'b0001);

    send(M_MINUS);
    check_mode("dead0", 4'h0, 4'h0, 4'h0);
    check("dead0_ready", 32'(req_ready), 32'd0);
    run_dead(bn, rl);
    check("p2m_busy_cycles", 32'(bn), 32'd100);
    check("p2m_ready_low", 32'(rl), 32'd100);
    check_mode("minus", 4'b0010, 4'b0001, 4'b0010);
    check("minus_ready", 32'(req_ready), 32'd1);

    err_n = 4'b1101;
    n = 0;
    while (top != 4'h0 && n < 6) begin
      tick();
      n++;
    end
    check("fault_latency", 32'(n), 32'd3);
    check("fault_flag", 32'(fault), 32'd1);
    check("fault_src", 32'(fault_src), 32'b0010);
    check("fault_ready", 32'(req_ready), 32'd1);

    send(M_PLUS);
    check("fault_discard_top", 32'(top), 32'd0);
    check("fault_discard_flag", 32'(fault), 32'd1);

    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_ignored_fault", 32'(fault), 32'd1);
    check("clr_ignored_src", 32'(fault_src), 32'b0010);

    err_n = 4'hF;
    repeat (3) tick();
    check("healthy_still_fault", 32'(fault), 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("clr_fault", 32'(fault), 32'd0);
    check("clr_src", 32'(fault_src), 32'd0);
    run_dead(bn, rl);
    check("clr_busy_cycles", 32'(bn), 32'd100);
    check_mode("after_clr", 4'h0, 4'h0, 4'h0);
    check("after_clr_ready", 32'(req_ready), 32'd1);

    send(M_BP);
    check_mode("bp", 4'b0100, 4'b1000, 4'b0100);
    send(M_ILL);
    check_mode("ill_dead", 4'h0, 4'h0, 4'h0);
    run_dead(bn, rl);
    check("ill_busy_cycles", 32'(bn), 32'd100);
    check_mode("ill_off", 4'h0, 4'h0, 4'h0);
    check("ill_off_ready", 32'(req_ready), 32'd1);

    send(M_OFF);
    check("off_noop_busy", 32'(busy), 32'd0);
    send(M_BN);
    check_mode("bn", 4'b1000, 4'b0100, 4'b1000);
    send(M_OFF);
    run_dead(bn, rl);
    check("bn_off_busy_cycles", 32'(bn), 32'd100);

    send(M_PLUS);
    repeat (10) tick();
`ifdef BRIDGE_MIN_ON_EN
    check("minon_ready_early", 32'(req_ready), 32'd0);
`else
    check("minon_ready_early", 32'(req_ready), 32'd1);
`endif
    req_mode = M_MINUS;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 1000) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
`ifdef BRIDGE_MIN_ON_EN
    check("minon_wait", 32'(n), 32'd490);
`else
    check("minon_wait", 32'(n), 32'd0);
`endif
    check("minon_dead", 32'(busy), 32'd1);
    run_dead(bn, rl);
    check("minon_busy_cycles", 32'(bn), 32'd100);
    check_mode("minon_minus", 4'b0010, 4'b0001, 4'b0010);

    send(M_PLUS);
    repeat (5) tick();
    #3 rst = 1'b1;
    #1;
    check("arst_top", 32'(top), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    tick();
    check("post_rst_busy", 32'(busy), 32'd0);
    send(M_PLUS);
    check_mode("post_rst_plus", 4'b0001, 4'b0010, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
